// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    // 0x8000_0000 maps to itself, which reads correctly as unsigned 2^31.
    function automatic logic [31:0] md_mag(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
//
// state | meaning
// IDLE  | waiting; start latches operands, otherwise MTHI/MTLO may write
// RUN   | one shift-add / restoring-subtract iteration per cycle, 32 cycles
// FIX   | sign correction, HI/LO write, done pulse
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e   state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] m_q, m_d;
    logic [31:0] a_raw_q, a_raw_d;
    logic [1:0]  op_q, op_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        is_mul;
    logic        start_signed;
    logic [32:0] alu_x, alu_y, alu_r;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;

    always_comb begin
        is_mul       = ~op_q[1];
        start_signed = ~op[0];

        // Multiply adds into P; divide subtracts from the left-shifted remainder.
        alu_x = is_mul ? {1'b0, acc_q[63:32]} : acc_q[63:31];
        alu_y = {1'b0, m_q};
        alu_r = is_mul ? (alu_x + alu_y) : (alu_x - alu_y);

        prod_fix = (sign_a_q ^ sign_b_q) ? (~acc_q + 64'd1) : acc_q;
        quot_fix = (sign_a_q ^ sign_b_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix  = sign_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        m_d      = m_q;
        a_raw_d  = a_raw_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    sign_a_d = start_signed & a[31];
                    sign_b_d = start_signed & b[31];
                    a_raw_d  = a;
                    dz_d     = (b == 32'd0);
                    count_d  = 5'd0;
                    if (op[1]) begin
                        m_d   = md_mag(b, start_signed);
                        acc_d = {32'd0, md_mag(a, start_signed)};
                    end else begin
                        m_d   = md_mag(a, start_signed);
                        acc_d = {32'd0, md_mag(b, start_signed)};
                    end
                    state_d = RUN;
                end else begin
                    if (hi_wr) hi_d = wr_data;
                    if (lo_wr) lo_d = wr_data;
                end
            end
            RUN: begin
                if (is_mul) begin
                    acc_d = acc_q[0] ? {alu_r, acc_q[31:1]} : {1'b0, acc_q[63:32], acc_q[31:1]};
                end else begin
                    // alu_r[32] is the borrow: set means the divisor did not fit.
                    acc_d = alu_r[32] ? {acc_q[62:0], 1'b0} : {alu_r[31:0], acc_q[30:0], 1'b1};
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'(MD_ITERS - 1)) state_d = FIX;
            end
            FIX: begin
                if (is_mul) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (dz_q) begin
                    hi_d = a_raw_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= 5'd0;
            acc_q    <= 64'd0;
            m_q      <= 32'd0;
            a_raw_q  <= 32'd0;
            op_q     <= MD_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            m_q      <= m_d;
            a_raw_q  <= a_raw_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit that serves MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. It sits directly downstream of the register-file read ports: rs/rt read data enter as operands, and the HI/LO outputs feed the writeback mux for MFHI/MFLO. The unit takes one operation at a time, runs 32 shift iterations plus one sign-fix cycle, and holds the pipeline through `busy`.

## Interface
- WIDTH, 32, operand/HI/LO width; only 32 is supported.
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin operation; sampled only when idle.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  32  rs operand (multiplicand or dividend).
- b  input  32  rt operand (multiplier or divisor).
- hi_wr  input  1  MTHI write strobe.
- lo_wr  input  1  MTLO write strobe.
- wr_data  input  32  MTHI/MTLO data.
- busy  output  1  operation in progress; combinational, high when state is not IDLE.
- done  output  1  registered, one-cycle pulse when HI/LO have been updated.
- hi  output  32  HI register.
- lo  output  32  LO register.

## Operation
- States:
  - IDLE: `start` latches operands and op, sets count to 0, and goes to RUN.
  - RUN: one iteration per cycle; leaves after count reaches 31.
  - FIX: sign correction and HI/LO write, then IDLE.
- Signed ops (MULT, DIV) capture magnitudes: |a|, |b|, sign_a, sign_b. 0x8000_0000 is used as unsigned magnitude 2^31.
- Multiply datapath:
  - Shift-add on a 64-bit accumulator {P, multiplier} with a 33-bit adder.
  - FIX negates the 64-bit product (two's complement) if sign_a ^ sign_b.
  - HI = product[63:32], LO = product[31:0].
- Divide datapath:
  - Restoring divide on the same 64-bit register with a 33-bit subtract.
  - FIX negates the quotient if sign_a ^ sign_b, and the remainder if sign_a.
  - LO = quotient, HI = remainder.
- Divide by zero (b == 0, either signedness): the iterations still run. FIX writes LO = 0xFFFF_FFFF and HI = a (raw operand), with no sign fix.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF produces LO = 0x8000_0000, HI = 0.
- MTHI/MTLO:
  - In IDLE with `start` = 0, `hi_wr`/`lo_wr` write `wr_data` into HI/LO at the clock edge.
  - Both strobes set in the same cycle write both registers.
- Collision and reset rules:
  - `start` while busy is ignored.
  - `hi_wr`/`lo_wr` while busy are ignored.
  - `start` together with `hi_wr`/`lo_wr` in IDLE: `start` wins and the writes are dropped.
  - `rst` mid-operation aborts to IDLE.
  - Operands `a`/`b` may change after the start cycle without effect.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0, count 0.
- Edge 0 samples `start`; `busy` is high from just after edge 0 until edge 33.
- RUN covers edges 1–32. Edge 33 is the FIX edge: HI/LO update, state returns to IDLE, `done` = 1 for the cycle following edge 33.
- Latency is 33 cycles from the `start` edge to valid HI/LO. Back-to-back issue is possible: a new `start` is accepted in the cycle `done` is high.
- HI/LO hold their previous values throughout RUN. Intermediate results are never visible.
- MTHI/MTLO take effect at the sampling edge and are visible in the next cycle.

## Structure
- Shared package `md_pkg`:
  - op encodings `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`;
  - state enum `IDLE`/`RUN`/`FIX`;
  - iteration count constant `MD_ITERS = 32`.
- Single module: the multiply and divide paths share one 64-bit shift register and one 33-bit adder/subtractor, so no sub-module is needed.
- The decoder upstream uses `busy` as a stall term for any MD instruction or MFHI/MFLO.

## Test plan
- MULTU a = 0xFFFF_FFFF, b = 0xFFFF_FFFF:
  - `busy` is high for 33 cycles;
  - then `done` pulses;
  - HI = 0xFFFF_FFFE, LO = 0x0000_0001.
- MULT a = 0xFFFF_FFFD (−3), b = 7 → HI = 0xFFFF_FFFF, LO = 0xFFFF_FFEB.
- DIV a = 0xFFFF_FFF9 (−7), b = 2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF.
- DIVU a = 100, b = 7 → LO = 0xE, HI = 0x2.
- DIVU a = 0x1234, b = 0 → LO = 0xFFFF_FFFF, HI = 0x1234.
- Boundary sequence:
  - second `start` at cycle 5 is ignored;
  - `hi_wr` with 0xAAAA_AAAA during busy is ignored;
  - `rst` asserted at cycle 10 of a later operation gives HI = LO = 0, `busy` = 0, `done` = 0;
  - MTLO 0x5555_5555 in IDLE gives LO = 0x5555_5555 in the next cycle.
